// File: rtl/pipe_shift_right.sv
// pipe_shift_right: pipelined log-structured right shifter (SHR/SAR, optional ROR)
// with an x86-style carry-out. One register stage per shift-amount bit, largest
// shift first, valid/ready on both sides with whole-pipeline backpressure.
// Optional feature macro: PSR_ROTATE_EN (rotate-right support via in_rot).
module pipe_shift_right #(
   parameter  int WIDTH = 32,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_arith,
   input  logic             in_rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_cf,
   output logic             out_cf_upd
);

   // A log shifter needs a power-of-two width so every stage shift is exact.
   if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipe_shift_right: WIDTH must be a power of two and at least 2");
   end

   // Stage registers, index 1 is the first stage after the input.
   logic             st_valid [1:AMT_W];
   logic [WIDTH-1:0] st_data  [1:AMT_W];
   logic [AMT_W-1:0] st_amt   [1:AMT_W];
   logic             st_fill  [1:AMT_W];
   logic             st_cf    [1:AMT_W];
   logic             st_upd   [1:AMT_W];

   // Combinational next values for each stage.
   logic             nxt_valid [1:AMT_W];
   logic [WIDTH-1:0] nxt_data  [1:AMT_W];
   logic [AMT_W-1:0] nxt_amt   [1:AMT_W];
   logic             nxt_fill  [1:AMT_W];
   logic             nxt_cf    [1:AMT_W];
   logic             nxt_upd   [1:AMT_W];

`ifdef PSR_ROTATE_EN
   logic             st_rot  [1:AMT_W];
   logic             nxt_rot [1:AMT_W];
`else
   logic             rot_unused;
   assign rot_unused = in_rot;
`endif

   logic             advance;
   logic             cap_fill;
   logic             cap_upd;

   // The whole pipe moves together whenever the last stage is empty or draining.
   assign advance  = !st_valid[AMT_W] || out_ready;
   assign in_ready = advance;

   // Fill bit and CF-update flag are fixed once, when the op enters the pipe.
   assign cap_fill = in_arith & in_data[WIDTH-1];
   assign cap_upd  = (in_amt != '0);

   // Per-stage shift: stage j consumes amount bit AMT_W-j with shift WIDTH>>j.
   always_comb begin
      logic             cur_valid;
      logic [WIDTH-1:0] cur_data;
      logic [AMT_W-1:0] cur_amt;
      logic             cur_fill;
      logic             cur_cf;
      logic             cur_upd;
      logic [WIDTH-1:0] fill_mask;
      logic [WIDTH-1:0] shifted;
`ifdef PSR_ROTATE_EN
      logic             cur_rot;
`endif
      for (int j = 1; j <= AMT_W; j++) begin
         if (j == 1) begin
            cur_valid = in_valid;
            cur_data  = in_data;
            cur_amt   = in_amt;
            cur_fill  = cap_fill;
            cur_cf    = 1'b0;
            cur_upd   = cap_upd;
`ifdef PSR_ROTATE_EN
            cur_rot   = in_rot;
`endif
         end else begin
            cur_valid = st_valid[j-1];
            cur_data  = st_data[j-1];
            cur_amt   = st_amt[j-1];
            cur_fill  = st_fill[j-1];
            cur_cf    = st_cf[j-1];
            cur_upd   = st_upd[j-1];
`ifdef PSR_ROTATE_EN
            cur_rot   = st_rot[j-1];
`endif
         end

         fill_mask = cur_fill ? ~({WIDTH{1'b1}} >> (WIDTH >> j)) : '0;
         shifted   = (cur_data >> (WIDTH >> j)) | fill_mask;
`ifdef PSR_ROTATE_EN
         if (cur_rot) begin
            shifted = (cur_data >> (WIDTH >> j)) | (cur_data << (WIDTH - (WIDTH >> j)));
         end
`endif

         nxt_valid[j] = cur_valid;
         nxt_fill[j]  = cur_fill;
         nxt_upd[j]   = cur_upd;
         nxt_amt[j]   = cur_amt;
         nxt_amt[j][AMT_W-j] = 1'b0;
`ifdef PSR_ROTATE_EN
         nxt_rot[j]   = cur_rot;
`endif
         if (cur_amt[AMT_W-j]) begin
            nxt_data[j] = shifted;
            nxt_cf[j]   = cur_data[(WIDTH >> j) - 1];
         end else begin
            nxt_data[j] = cur_data;
            nxt_cf[j]   = cur_cf;
         end
      end
   end

   // Stage registers: async clear, all stages load together on advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 1; j <= AMT_W; j++) begin
            st_valid[j] <= 1'b0;
            st_data[j]  <= '0;
            st_amt[j]   <= '0;
            st_fill[j]  <= 1'b0;
            st_cf[j]    <= 1'b0;
            st_upd[j]   <= 1'b0;
`ifdef PSR_ROTATE_EN
            st_rot[j]   <= 1'b0;
`endif
         end
      end else if (advance) begin
         for (int j = 1; j <= AMT_W; j++) begin
            st_valid[j] <= nxt_valid[j];
            st_data[j]  <= nxt_data[j];
            st_amt[j]   <= nxt_amt[j];
            st_fill[j]  <= nxt_fill[j];
            st_cf[j]    <= nxt_cf[j];
            st_upd[j]   <= nxt_upd[j];
`ifdef PSR_ROTATE_EN
            st_rot[j]   <= nxt_rot[j];
`endif
         end
      end
   end

   assign out_valid  = st_valid[AMT_W];
   assign out_data   = st_data[AMT_W];
   assign out_cf     = st_cf[AMT_W];
   assign out_cf_upd = st_upd[AMT_W];

endmodule

// File: tb/tb_pipe_shift_right.sv
// tb_pipe_shift_right: directed scoreboard bench for pipe_shift_right (WIDTH=32).
// Stimulus pushes hand-computed results into a queue; a monitor pops on each
// output transfer, and also checks stall stability and in_ready during stalls.
module tb_pipe_shift_right;

   localparam int WIDTH = 32;
   localparam int AMT_W = 5;

   typedef struct packed {
      logic [31:0] data;
      logic        cf;
      logic        upd;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic        in_arith;
   logic        in_rot;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_cf;
   logic        out_cf_upd;

   exp_t        expQ[$];
   exp_t        monExp;
   exp_t        held;
   logic        holdPending;
   int          checks;
   int          errors;

   pipe_shift_right #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_amt     (in_amt),
      .in_arith   (in_arith),
      .in_rot     (in_rot),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_cf     (out_cf),
      .out_cf_upd (out_cf_upd)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a failure line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Offer one op, wait (bounded) for acceptance, record its expected result.
   task automatic applyStimulus(input logic [31:0] d, input logic [4:0] a, input logic arith,
                                input logic rot, input logic [31:0] ed, input logic ec,
                                input logic eu);
      int budget;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_arith = arith;
      in_rot   = rot;
      budget   = 0;
      @(negedge clk);
      while (!in_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got in_ready=0, expected in_ready=1 within 100 cycles");
      end else begin
         expQ.push_back('{data: ed, cf: ec, upd: eu});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until every expected result has been delivered.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_drain_left"}, expQ.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: stall stability, in_ready during stall, and scoreboard pops.
   always @(negedge clk) begin
      if (rst) begin
         holdPending = 1'b0;
      end else begin
         if (holdPending) begin
            checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_data", out_data, held.data);
            checkOutput("hold_cf", {31'b0, out_cf}, {31'b0, held.cf});
            checkOutput("hold_cf_upd", {31'b0, out_cf_upd}, {31'b0, held.upd});
            holdPending = 1'b0;
         end
         if (out_valid && !out_ready) begin
            checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
            held        = '{data: out_data, cf: out_cf, upd: out_cf_upd};
            holdPending = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got data 0x%08h, expected no output", out_data);
            end else begin
               monExp = expQ.pop_front();
               checkOutput("out_data", out_data, monExp.data);
               checkOutput("out_cf", {31'b0, out_cf}, {31'b0, monExp.cf});
               checkOutput("out_cf_upd", {31'b0, out_cf_upd}, {31'b0, monExp.upd});
            end
         end
      end
   end

   // Hard stop in case something wedges beyond every bounded wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   // Hand-computed results for the back-to-back run: (i<<8) >> i, cf always 0.
   logic [31:0] b2bExp [8] = '{32'h0000_0000, 32'h0000_0080, 32'h0000_0080, 32'h0000_0060,
                               32'h0000_0040, 32'h0000_0028, 32'h0000_0018, 32'h0000_000E};

   // Directed test sequence.
   initial begin
      int lat;
      checks      = 0;
      errors      = 0;
      holdPending = 1'b0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_amt      = '0;
      in_arith    = 1'b0;
      in_rot      = 1'b0;
      out_ready   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      checkOutput("rst_out_cf", {31'b0, out_cf}, 32'd0);
      checkOutput("rst_out_cf_upd", {31'b0, out_cf_upd}, 32'd0);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst       = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] SAR with latency");
      applyStimulus(32'h8000_0000, 5'd4, 1'b1, 1'b0, 32'hF800_0000, 1'b0, 1'b1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      checkOutput("latency", lat, AMT_W);
      waitDrain("sar");

      $display("[TB] SHR and zero amount");
      applyStimulus(32'h0000_000F, 5'd2, 1'b0, 1'b0, 32'h0000_0003, 1'b1, 1'b1);
      applyStimulus(32'h1234_5678, 5'd0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
      waitDrain("shr");

      $display("[TB] maximum amount");
      applyStimulus(32'hC000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b1);
      applyStimulus(32'hC000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
      waitDrain("max");

`ifdef PSR_ROTATE_EN
      $display("[TB] rotate");
      applyStimulus(32'h0000_0001, 5'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
      applyStimulus(32'h0000_F000, 5'd12, 1'b0, 1'b1, 32'h0000_000F, 1'b0, 1'b1);
      applyStimulus(32'h8000_0001, 5'd1, 1'b1, 1'b1, 32'hC000_0000, 1'b1, 1'b1);
      waitDrain("rot");
`else
      $display("[TB] rotate request ignored");
      applyStimulus(32'h0000_0001, 5'd1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
      applyStimulus(32'h8000_0001, 5'd1, 1'b1, 1'b1, 32'hC000_0000, 1'b1, 1'b1);
      waitDrain("norot");
`endif

      $display("[TB] back-to-back with backpressure");
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               applyStimulus(32'(i) << 8, 5'(i), 1'b0, 1'b0, b2bExp[i], 1'b0, (i != 0));
            end
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      waitDrain("b2b");

      $display("[TB] reset with ops in flight");
      out_ready = 1'b0;
      applyStimulus(32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b1);
      applyStimulus(32'hFFFF_0000, 5'd8, 1'b1, 1'b0, 32'hFFFF_FF00, 1'b0, 1'b1);
      applyStimulus(32'h0000_0100, 5'd1, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      expQ.delete();
      checkOutput("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("async_rst_out_data", out_data, 32'd0);
      checkOutput("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      applyStimulus(32'h0000_0A00, 5'd9, 1'b0, 1'b0, 32'h0000_0005, 1'b0, 1'b1);
      waitDrain("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
